emsensor_ctrl: RTL and testbench

Sequencing and alarm-collection controller for an array of EM sensor cells in the emsensor coprocessor. It holds the cells in reset, releases them, and masks their settling window. It then monitors their alarm outputs with a persistence filter, latching a per-cell alarm vector and raising an interrupt to the host when tripped. The block sits between the sensor-cell array, which shares `clk`, and the coprocessor register interface.

---
 rtl/emsensor_ctrl.sv | 152 +++++++++++++++
 tb/tb_emsensor_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/emsensor_ctrl.sv
// Sequencing and alarm-collection controller for an EM sensor cell array:
// resets and warms up the cells, then persistence-filters their alarms into a latched trip.
module emsensor_ctrl #(
  parameter int N_CELLS = 16,
  parameter int RST_CYC = 4,
  parameter int WARMUP  = 8,
  parameter int THRESH  = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr,
  input  logic [N_CELLS-1:0] mask,
  input  logic [N_CELLS-1:0] cell_alarm,
  output logic               cell_rst,
  output logic               alarm_irq,
  output logic [N_CELLS-1:0] alarm_vec,
  output logic [CNT_W-1:0]   alarm_cnt,
  output logic [2:0]         state
);

  localparam int TMR_MAX = (RST_CYC > WARMUP) ? RST_CYC : WARMUP;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int STK_W   = $clog2(THRESH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WARM = 3'd2,
    S_MON  = 3'd3,
    S_TRIP = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [STK_W-1:0]   streak_q, streak_d;
  logic [N_CELLS-1:0] streak_vec_q, streak_vec_d;
  logic [N_CELLS-1:0] alarm_q;
  logic [N_CELLS-1:0] alarm_vec_q, alarm_vec_d;
  logic [CNT_W-1:0]   alarm_cnt_q, alarm_cnt_d;
  logic               cell_rst_q, cell_rst_d;
  logic               alarm_irq_q, alarm_irq_d;
  logic               hit;

  assign hit = |alarm_q;

  // NOTE: every signal gets its default first, so no path through the case can infer a latch.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    streak_d     = streak_q;
    streak_vec_d = streak_vec_q;
    alarm_vec_d  = alarm_vec_q;
    alarm_cnt_d  = alarm_cnt_q;

    if (!en) begin
      state_d      = S_IDLE;
      timer_d      = '0;
      streak_d     = '0;
      streak_vec_d = '0;
      alarm_vec_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          timer_d = '0;
        end
        S_ARM: begin
          if (timer_q == TMR_W'(RST_CYC - 1)) begin
            state_d = S_WARM;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_WARM: begin
          if (timer_q == TMR_W'(WARMUP - 1)) begin
            state_d      = S_MON;
            timer_d      = '0;
            streak_d     = '0;
            streak_vec_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_MON: begin
          if (!hit) begin
            streak_d     = '0;
            streak_vec_d = '0;
          end else if (streak_q == STK_W'(THRESH - 1)) begin
            // Trip edge: the latched vector includes this cycle's sample.
            state_d      = S_TRIP;
            alarm_vec_d  = streak_vec_q | alarm_q;
            streak_d     = '0;
            streak_vec_d = '0;
            if (alarm_cnt_q != '1) alarm_cnt_d = alarm_cnt_q + 1'b1;
          end else begin
            streak_d     = streak_q + 1'b1;
            streak_vec_d = streak_vec_q | alarm_q;
          end
        end
        S_TRIP: begin
          if (clr) begin
            state_d      = S_ARM;
            timer_d      = '0;
            streak_d     = '0;
            streak_vec_d = '0;
            alarm_vec_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they leave the block registered.
    cell_rst_d  = (state_d == S_WARM) || (state_d == S_MON) || (state_d == S_TRIP);
    alarm_irq_d = (state_d == S_TRIP);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      streak_q     <= '0;
      streak_vec_q <= '0;
      alarm_q      <= '0;
      alarm_vec_q  <= '0;
      alarm_cnt_q  <= '0;
      cell_rst_q   <= 1'b0;
      alarm_irq_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      streak_q     <= streak_d;
      streak_vec_q <= streak_vec_d;
      alarm_q      <= cell_alarm & ~mask;
      alarm_vec_q  <= alarm_vec_d;
      alarm_cnt_q  <= alarm_cnt_d;
      cell_rst_q   <= cell_rst_d;
      alarm_irq_q  <= alarm_irq_d;
    end
  end

  assign cell_rst  = cell_rst_q;
  assign alarm_irq = alarm_irq_q;
  assign alarm_vec = alarm_vec_q;
  assign alarm_cnt = alarm_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_emsensor_ctrl.sv
// Directed bench for emsensor_ctrl: a default instance plus a CNT_W=2 instance share stimulus;
// expected trip results are queued when alarms are driven and popped when the trip appears.
module tb_emsensor_ctrl;

  localparam int RST_CYC = 4;
  localparam int WARMUP  = 8;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [15:0] mask, cell_alarm;

  logic        cell_rst, alarm_irq;
  logic [15:0] alarm_vec, alarm_cnt;
  logic [2:0]  state;

  logic        cell_rst2, alarm_irq2;
  logic [15:0] alarm_vec2;
  logic [1:0]  alarm_cnt2;
  logic [2:0]  state2;

  typedef struct {
    logic [15:0] vec;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } trip_t;

  trip_t sb_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    trips = 0;

  always #5 clk = ~clk;

  emsensor_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mask(mask), .cell_alarm(cell_alarm),
    .cell_rst(cell_rst), .alarm_irq(alarm_irq), .alarm_vec(alarm_vec),
    .alarm_cnt(alarm_cnt), .state(state)
  );

  emsensor_ctrl #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mask(mask), .cell_alarm(cell_alarm),
    .cell_rst(cell_rst2), .alarm_irq(alarm_irq2), .alarm_vec(alarm_vec2),
    .alarm_cnt(alarm_cnt2), .state(state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after the edge that entered ARM; walks the reset and warm-up windows.
  task automatic run_arm(input string tag);
    for (int i = 1; i < RST_CYC; i++) begin
      tick(1);
      check({tag, "_arm_state"}, 32'(state), 32'd1);
      check({tag, "_arm_cellrst"}, 32'(cell_rst), 32'd0);
    end
    tick(1);
    check({tag, "_warm_state"}, 32'(state), 32'd2);
    check({tag, "_warm_cellrst"}, 32'(cell_rst), 32'd1);
    tick(WARMUP - 1);
    check({tag, "_warm_hold"}, 32'(state), 32'd2);
    tick(1);
    check({tag, "_mon_state"}, 32'(state), 32'd3);
  endtask

  function automatic void expect_trip(input logic [15:0] vec);
    trip_t t;
    trips++;
    t.vec  = vec;
    t.cnt  = 16'(trips);
    t.cnt2 = (trips > 3) ? 2'd3 : 2'(trips);
    sb_q.push_back(t);
  endfunction

  task automatic check_trip(input string tag);
    trip_t t;
    check({tag, "_sb_pending"}, 32'(sb_q.size() > 0), 32'd1);
    if (sb_q.size() > 0) begin
      t = sb_q.pop_front();
      check({tag, "_state"}, 32'(state), 32'd4);
      check({tag, "_irq"}, 32'(alarm_irq), 32'd1);
      check({tag, "_cellrst"}, 32'(cell_rst), 32'd1);
      check({tag, "_vec"}, 32'(alarm_vec), 32'(t.vec));
      check({tag, "_cnt"}, 32'(alarm_cnt), 32'(t.cnt));
      check({tag, "_cnt_w2"}, 32'(alarm_cnt2), 32'(t.cnt2));
    end
  endtask

  // Alarm driven before edges e and e+1; the trip must show after e+2, not earlier.
  task automatic trip_now(input string tag, input logic [15:0] m, input logic [15:0] a,
                          input logic [15:0] exp_vec, input bit hold);
    mask       = m;
    cell_alarm = a;
    expect_trip(exp_vec);
    tick(2);
    check({tag, "_pre"}, 32'(state), 32'd3);
    if (!hold) cell_alarm = '0;
    tick(1);
    check_trip(tag);
  endtask

  task automatic clear_trip(input string tag);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check({tag, "_state"}, 32'(state), 32'd1);
    check({tag, "_irq"}, 32'(alarm_irq), 32'd0);
    check({tag, "_vec"}, 32'(alarm_vec), 32'd0);
    check({tag, "_cellrst"}, 32'(cell_rst), 32'd0);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; mask = '0; cell_alarm = '0;
    #12;
    check("rst_state", 32'(state), 32'd0);
    check("rst_cellrst", 32'(cell_rst), 32'd0);
    check("rst_irq", 32'(alarm_irq), 32'd0);
    check("rst_vec", 32'(alarm_vec), 32'd0);
    check("rst_cnt", 32'(alarm_cnt), 32'd0);

    tick(1);
    rst = 1'b1;
    tick(2);
    check("idle_hold", 32'(state), 32'd0);

    en = 1'b1;
    tick(1);
    check("e0_state", 32'(state), 32'd1);
    check("e0_cellrst", 32'(cell_rst), 32'd0);
    run_arm("first");

    // Single-cycle burst must not trip.
    cell_alarm = 16'h0020;
    tick(1);
    cell_alarm = '0;
    tick(4);
    check("short_state", 32'(state), 32'd3);
    check("short_irq", 32'(alarm_irq), 32'd0);
    check("short_cnt", 32'(alarm_cnt), 32'd0);

    trip_now("trip1", 16'h0000, 16'h0020, 16'h0020, 1'b0);

    clear_trip("clr1");
    run_arm("rearm1");

    // Masked cell 5 dropped from the vector; alarms during TRIP are ignored.
    trip_now("trip2", 16'h0020, 16'h0021, 16'h0001, 1'b1);
    cell_alarm = 16'h003f;
    tick(3);
    check("trip2_held_vec", 32'(alarm_vec), 32'h0001);
    check("trip2_held_state", 32'(state), 32'd4);

    clear_trip("clr2");
    run_arm("rearm2");
    mask       = 16'h0020;
    cell_alarm = 16'h0020;
    tick(6);
    check("masked_state", 32'(state), 32'd3);
    check("masked_irq", 32'(alarm_irq), 32'd0);
    cell_alarm = '0;
    tick(1);

    trip_now("trip3", 16'h0000, 16'h8001, 16'h8001, 1'b0);

    // en low wins over clr.
    en  = 1'b0;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("dis_state", 32'(state), 32'd0);
    check("dis_irq", 32'(alarm_irq), 32'd0);
    check("dis_cellrst", 32'(cell_rst), 32'd0);
    check("dis_vec", 32'(alarm_vec), 32'd0);
    check("dis_cnt", 32'(alarm_cnt), 32'd3);
    tick(2);
    check("dis_hold", 32'(state), 32'd0);

    en = 1'b1;
    tick(1);
    check("reen_state", 32'(state), 32'd1);
    run_arm("reen");
    for (int k = 0; k < 3; k++) begin
      trip_now($sformatf("sat%0d", k), 16'h0000, 16'h0001 << k, 16'h0001 << k, 1'b0);
      clear_trip($sformatf("sat_clr%0d", k));
      run_arm($sformatf("sat_arm%0d", k));
    end
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // Async reset in the middle of WARM: take effect before the next edge.
    trip_now("trip7", 16'h0000, 16'h4000, 16'h4000, 1'b0);
    clear_trip("clr7");
    tick(RST_CYC + 2);
    check("midwarm_state", 32'(state), 32'd2);
    #3;
    rst = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_cellrst", 32'(cell_rst), 32'd0);
    check("arst_irq", 32'(alarm_irq), 32'd0);
    check("arst_vec", 32'(alarm_vec), 32'd0);
    check("arst_cnt", 32'(alarm_cnt), 32'd0);
    check("arst_cnt_w2", 32'(alarm_cnt2), 32'd0);
    check("arst_state_w2", 32'(state2), 32'd0);

    #20;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
